// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C register-file slave.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT
  } i2c_state_t;

  // Bus-level bit meanings
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic I2C_WR   = 1'b0;
  localparam logic I2C_RD   = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronises one raw I2C line, debounces it and emits edge pulses.
// Latency: 2 sync flops + FILTER_LEN samples before line_f follows a stable change.
// Backpressure: none; free-running conditioner.
//
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   line_in     raw pin level (asynchronous)
//   line_f      filtered level, resets to 1 (idle bus)
//   rise, fall  one-cycle pulses, asserted in the cycle line_f changes
module i2c_line_filter
  import i2c_slave_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic line_f,
  output logic rise,
  output logic fall
);

  localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

  logic [1:0] sync;
  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync   <= 2'b11;
      cnt    <= 4'd0;
      line_f <= 1'b1;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync <= {sync[0], line_in};
      rise <= 1'b0;
      fall <= 1'b0;
      // cnt counts consecutive samples that disagree with line_f; any
      // agreeing sample restarts the run, so short glitches are dropped.
      if (sync[1] == line_f) begin
        cnt <= 4'd0;
      end else if (cnt == CNT_LAST) begin
        line_f <= sync[1];
        cnt    <= 4'd0;
        rise   <= sync[1];
        fall   <= ~sync[1];
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing NUM_REGS bytes with pointer addressing and burst access.
// Latency: writes commit one clk after the 8th data SCL rise; SDA updates follow filtered SCL fall.
// Backpressure: none; never stretches SCL, bus master sets the pace.
//
// Ports:
//   clk, reset   system clock (>= 20x SCL), synchronous active-high reset
//   scl_in       raw SCL pin level
//   sda_in       raw SDA pin level
//   sda_oe       1 = pull SDA low, 0 = release (open-drain)
//   reg_out      register file, byte i at [8i+7:8i]
//   reg_wr_stb   one-cycle pulse per register write
//   reg_wr_idx   index written, valid with reg_wr_stb
//   busy         high from address ACK until STOP or slave NACK
module i2c_slave_regfile
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h27,
  parameter int         NUM_REGS   = 4,
  parameter logic [7:0] RESET_VAL  = 8'h00,
  parameter int         FILTER_LEN = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        scl_in,
  input  logic                        sda_in,
  output logic                        sda_oe,
  output logic [8*NUM_REGS-1:0]       reg_out,
  output logic                        reg_wr_stb,
  output logic [$clog2(NUM_REGS)-1:0] reg_wr_idx,
  output logic                        busy
);

  localparam int PW = $clog2(NUM_REGS);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk     (clk),
    .reset   (reset),
    .line_in (scl_in),
    .line_f  (scl_f),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk     (clk),
    .reset   (reset),
    .line_in (sda_in),
    .line_f  (sda_f),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  // Both filters have identical delay, so SDA/SCL ordering is preserved.
  logic start_det, stop_det;
  assign start_det = sda_fall & scl_f;
  assign stop_det  = sda_rise & scl_f;

  i2c_state_t          state;
  logic [3:0]          bit_cnt;
  logic [7:0]          shreg;
  logic                rw;
  logic [PW-1:0]       ptr;
  logic                wr_pend;
  logic [8*NUM_REGS-1:0] regs;

  assign reg_out = regs;

  logic [7:0]    rd_byte;
  logic [PW-1:0] ptr_inc;
  logic          ptr_ok;

  assign rd_byte = regs[{ptr, 3'b000} +: 8];
  assign ptr_inc = (ptr == PW'(NUM_REGS - 1)) ? '0 : ptr + 1'b1;
  assign ptr_ok  = ({1'b0, shreg} < 9'(NUM_REGS));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      shreg      <= 8'd0;
      rw         <= I2C_WR;
      ptr        <= '0;
      wr_pend    <= 1'b0;
      regs       <= {NUM_REGS{RESET_VAL}};
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      reg_wr_stb <= 1'b0;
      reg_wr_idx <= '0;
    end else begin
      reg_wr_stb <= 1'b0;
      wr_pend    <= 1'b0;

      // Commit the byte shifted in during WDATA on the cycle after its 8th rise.
      if (wr_pend) begin
        regs[{ptr, 3'b000} +: 8] <= shreg;
        reg_wr_stb               <= 1'b1;
        reg_wr_idx               <= ptr;
        ptr                      <= ptr_inc;
      end

      // START/STOP override any SCL edge seen in the same cycle.
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
          end

          ADDR: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shreg   <= {shreg[6:0], sda_f};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (shreg[7:1] == SLAVE_ADDR) begin
                sda_oe <= 1'b1;
                busy   <= 1'b1;
                rw     <= shreg[0];
                state  <= ADDR_ACK;
              end else begin
                busy  <= 1'b0;
                state <= WAIT;
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              if (rw == I2C_WR) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= PTR;
              end else begin
                // First read byte: MSB goes out on this same fall.
                shreg   <= rd_byte;
                sda_oe  <= ~rd_byte[7];
                bit_cnt <= 4'd1;
                state   <= RDATA;
              end
            end
          end

          PTR: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shreg   <= {shreg[6:0], sda_f};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (ptr_ok) begin
                ptr    <= shreg[PW-1:0];
                sda_oe <= 1'b1;
                state  <= PTR_ACK;
              end else begin
                busy  <= 1'b0;
                state <= WAIT;
              end
            end
          end

          PTR_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= WDATA;
            end
          end

          WDATA: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shreg   <= {shreg[6:0], sda_f};
              bit_cnt <= bit_cnt + 4'd1;
              wr_pend <= (bit_cnt == 4'd7);
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_oe <= 1'b1;
              state  <= WDATA_ACK;
            end
          end

          WDATA_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= WDATA;
            end
          end

          RDATA: begin
            // bit_cnt counts bits already placed on the bus.
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= RDATA_ACK;
              end else begin
                shreg   <= {shreg[6:0], 1'b0};
                sda_oe  <= ~shreg[6];
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          RDATA_ACK: begin
            // bit_cnt == 9 marks "master ACKed, reload on the next fall".
            if (scl_rise && bit_cnt == 4'd8) begin
              ptr <= ptr_inc;
              if (sda_f == I2C_ACK) begin
                bit_cnt <= 4'd9;
              end else begin
                state <= WAIT;
              end
            end else if (scl_fall && bit_cnt == 4'd9) begin
              shreg   <= rd_byte;
              sda_oe  <= ~rd_byte[7];
              bit_cnt <= 4'd1;
              state   <= RDATA;
            end
          end

          WAIT: begin
            sda_oe <= 1'b0;
          end

          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-banged I2C master plus transaction-level register model.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2c_slave_regfile;

  localparam int         N     = 4;
  localparam logic [6:0] SADDR = 7'h27;
  localparam logic [7:0] RV    = 8'h00;
  localparam int         FL    = 3;
  localparam int         Q     = 6;   // quarter SCL period in clk cycles

  logic         clk = 1'b0;
  logic         reset;
  logic         scl_m;
  logic         sda_m;
  logic         sda_bus;
  logic         sda_oe;
  logic [8*N-1:0] reg_out;
  logic         reg_wr_stb;
  logic [1:0]   reg_wr_idx;
  logic         busy;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_regfile #(
    .SLAVE_ADDR (SADDR),
    .NUM_REGS   (N),
    .RESET_VAL  (RV),
    .FILTER_LEN (FL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .scl_in     (scl_m),
    .sda_in     (sda_bus),
    .sda_oe     (sda_oe),
    .reg_out    (reg_out),
    .reg_wr_stb (reg_wr_stb),
    .reg_wr_idx (reg_wr_idx),
    .busy       (busy)
  );

  typedef struct {
    bit         is_data;
    logic [7:0] val;
  } bus_ev_t;

  bus_ev_t     exp_bus_q[$];
  bus_ev_t     obs_bus_q[$];
  logic [15:0] exp_wr_q[$];
  logic [7:0]  tx_q[$];

  int n_checks;
  int n_fail;
  int oe_cnt;
  int stb_cnt;

  logic [7:0] model_regs[N];
  int         model_ptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [8*N-1:0] model_pack();
    logic [8*N-1:0] p;
    for (int i = 0; i < N; i++) p[8*i +: 8] = model_regs[i];
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) model_regs[i] = RV;
    model_ptr = 0;
  endtask

  task automatic push_exp(input bit d, input logic [7:0] v);
    exp_bus_q.push_back('{is_data: d, val: v});
  endtask

  task automatic push_obs(input bit d, input logic [7:0] v);
    obs_bus_q.push_back('{is_data: d, val: v});
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL clock: SDA set mid-low, sampled mid-high. Optional short SCL glitch while low.
  task automatic put_bit(input logic b, input bit glitch, output logic s);
    wait_clk(Q);
    sda_m = b;
    if (glitch) begin
      wait_clk(2);
      scl_m = 1'b1;
      wait_clk(FL - 1);
      scl_m = 1'b0;
      wait_clk(Q - 2 - (FL - 1));
    end else begin
      wait_clk(Q);
    end
    scl_m = 1'b1;
    wait_clk(Q);
    s = sda_bus;
    wait_clk(Q);
    scl_m = 1'b0;
  endtask

  task automatic start_cond();
    sda_m = 1'b1;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(Q);
    sda_m = 1'b0;
    wait_clk(Q);
    scl_m = 1'b0;
  endtask

  task automatic stop_cond();
    sda_m = 1'b0;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(Q);
    sda_m = 1'b1;
    wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gl_bit, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) put_bit(b[i], (i == gl_bit), s);
    put_bit(1'b1, 1'b0, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] v);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      put_bit(1'b1, 1'b0, s);
      v[i] = s;
    end
    put_bit(mack, 1'b0, s);
  endtask

  // Write transaction of tx_q: first byte is the pointer, the rest data.
  task automatic xfer_write(input logic [6:0] addr, input int gl_byte, input int gl_bit,
                            input bit do_stop);
    bit   match;
    bit   ok;
    logic a;
    match = (addr == SADDR);
    ok    = 1'b0;
    push_exp(1'b0, {7'd0, ~match});
    for (int k = 0; k < tx_q.size(); k++) begin
      if (!match) begin
        push_exp(1'b0, 8'd1);
      end else if (k == 0) begin
        ok = (int'(tx_q[0]) < N);
        push_exp(1'b0, {7'd0, ~ok});
        if (ok) model_ptr = int'(tx_q[0]);
      end else if (ok) begin
        exp_wr_q.push_back({8'(model_ptr), tx_q[k]});
        model_regs[model_ptr] = tx_q[k];
        model_ptr = (model_ptr + 1) % N;
        push_exp(1'b0, 8'd0);
      end else begin
        push_exp(1'b0, 8'd1);
      end
    end
    start_cond();
    send_byte({addr, 1'b0}, -1, a);
    push_obs(1'b0, {7'd0, a});
    for (int k = 0; k < tx_q.size(); k++) begin
      send_byte(tx_q[k], (k == gl_byte) ? gl_bit : -1, a);
      push_obs(1'b0, {7'd0, a});
    end
    if (do_stop) begin
      stop_cond();
      wait_clk(10);
    end
  endtask

  // Read n bytes from the current pointer; master NACKs the last one.
  task automatic xfer_read(input int n, input bit do_stop);
    logic       a;
    logic [7:0] v;
    push_exp(1'b0, 8'd0);
    for (int i = 0; i < n; i++) begin
      push_exp(1'b1, model_regs[model_ptr]);
      model_ptr = (model_ptr + 1) % N;
    end
    start_cond();
    send_byte({SADDR, 1'b1}, -1, a);
    push_obs(1'b0, {7'd0, a});
    for (int i = 0; i < n; i++) begin
      recv_byte((i == n - 1) ? 1'b1 : 1'b0, v);
      push_obs(1'b1, v);
    end
    if (do_stop) begin
      stop_cond();
      wait_clk(10);
    end
  endtask

  initial begin
    int         s0;
    int         o0;
    logic       a;
    logic       s;
    logic [7:0] d;
    n_checks = 0;
    n_fail   = 0;
    oe_cnt   = 0;
    stb_cnt  = 0;
    model_reset();
    scl_m = 1'b1;
    sda_m = 1'b1;
    reset = 1'b1;

    fork
      begin : watchdog
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
      end
      begin : bus_monitor
        bus_ev_t o;
        bus_ev_t e;
        forever begin
          @(negedge clk);
          while (obs_bus_q.size() > 0) begin
            o = obs_bus_q.pop_front();
            if (exp_bus_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_bus_event: got %0d/%h, expected nothing", o.is_data, o.val);
            end else begin
              e = exp_bus_q.pop_front();
              check(e.is_data ? "rdata" : "ack", 32'({o.is_data, o.val}), 32'({e.is_data, e.val}));
            end
          end
        end
      end
      begin : wr_monitor
        logic [15:0] w;
        forever begin
          @(negedge clk);
          if (sda_oe === 1'b1) oe_cnt++;
          if (reg_wr_stb === 1'b1) begin
            stb_cnt++;
            if (exp_wr_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_wr_stb: got idx %0d, expected no strobe", reg_wr_idx);
            end else begin
              w = exp_wr_q.pop_front();
              check("wr_idx", 32'(reg_wr_idx), 32'(w[15:8]));
              check("wr_data", 32'(reg_out[{reg_wr_idx, 3'b000} +: 8]), 32'(w[7:0]));
            end
          end
        end
      end
    join_none

    // Reset state
    wait_clk(5);
    reset = 1'b0;
    @(negedge clk);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_stb", 32'(reg_wr_stb), 32'd0);
    check("rst_wr_idx", 32'(reg_wr_idx), 32'd0);
    check("rst_reg_out", 32'(reg_out), 32'({N{RV}}));
    wait_clk(10);

    // Single write to reg1
    tx_q = '{8'h01, 8'h8D};
    s0 = stb_cnt;
    xfer_write(SADDR, -1, -1, 1'b1);
    check("t1_reg1", 32'(reg_out[15:8]), 32'h8D);
    check("t1_reg_out", 32'(reg_out), 32'(model_pack()));
    check("t1_stb_count", 32'(stb_cnt - s0), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);

    // Burst write wrapping past the last register
    tx_q = '{8'h03, 8'hAA, 8'hBB, 8'hCC};
    s0 = stb_cnt;
    xfer_write(SADDR, -1, -1, 1'b1);
    check("t2_reg_out", 32'(reg_out), 32'(model_pack()));
    check("t2_stb_count", 32'(stb_cnt - s0), 32'd3);
    xfer_read(1, 1'b1);

    // Pointer set, repeated START, burst read ending in master NACK
    tx_q = '{8'h01};
    xfer_write(SADDR, -1, -1, 1'b0);
    xfer_read(2, 1'b0);
    wait_clk(10);
    check("t3_busy_wait", 32'(busy), 32'd1);
    stop_cond();
    wait_clk(10);
    check("t3_busy_stop", 32'(busy), 32'd0);

    // Wrong device address
    tx_q = '{8'h00, 8'h55};
    s0 = stb_cnt;
    o0 = oe_cnt;
    xfer_write(7'h28, -1, -1, 1'b1);
    check("t4_oe_cycles", 32'(oe_cnt - o0), 32'd0);
    check("t4_stb_count", 32'(stb_cnt - s0), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_reg_out", 32'(reg_out), 32'(model_pack()));

    // Out-of-range pointer
    tx_q = '{8'h07, 8'h11, 8'h22};
    s0 = stb_cnt;
    xfer_write(SADDR, -1, -1, 1'b1);
    check("t5_stb_count", 32'(stb_cnt - s0), 32'd0);
    check("t5_reg_out", 32'(reg_out), 32'(model_pack()));
    xfer_read(1, 1'b1);

    // Short SCL glitch inside a data byte
    tx_q = '{8'h00, 8'hA5};
    xfer_write(SADDR, 1, 3, 1'b1);
    check("t6_reg_out", 32'(reg_out), 32'(model_pack()));

    // Reset while the slave is driving a write ACK
    push_exp(1'b0, 8'd0);
    push_exp(1'b0, 8'd0);
    exp_wr_q.push_back({8'd2, 8'h3C});
    model_regs[2] = 8'h3C;
    model_ptr = 3;
    start_cond();
    send_byte({SADDR, 1'b0}, -1, a);
    push_obs(1'b0, {7'd0, a});
    send_byte(8'h02, -1, a);
    push_obs(1'b0, {7'd0, a});
    d = 8'h3C;
    for (int i = 7; i >= 0; i--) put_bit(d[i], 1'b0, s);
    for (int k = 0; k < 30 && sda_oe !== 1'b1; k++) @(negedge clk);
    check("t7_oe_before", 32'(sda_oe), 32'd1);
    check("t7_reg_before", 32'(reg_out), 32'(model_pack()));
    reset = 1'b1;
    sda_m = 1'b1;
    @(negedge clk);
    check("t7_oe_after", 32'(sda_oe), 32'd0);
    check("t7_reg_after", 32'(reg_out), 32'({N{RV}}));
    check("t7_busy_after", 32'(busy), 32'd0);
    model_reset();
    reset = 1'b0;
    wait_clk(10);
    stop_cond();
    wait_clk(10);
    xfer_read(1, 1'b1);

    // Randomised mix of writes, reads and write-pointer/restart/read
    for (int it = 0; it < 24; it++) begin
      int kind;
      int nb;
      kind = int'($urandom_range(0, 2));
      nb   = int'($urandom_range(1, 3));
      if (kind == 0) begin
        tx_q = '{};
        tx_q.push_back(8'($urandom_range(0, 5)));
        for (int k = 0; k < nb; k++) tx_q.push_back(8'($urandom_range(0, 255)));
        xfer_write(SADDR, -1, -1, 1'b1);
      end else if (kind == 1) begin
        xfer_read(nb, 1'b1);
      end else begin
        tx_q = '{};
        tx_q.push_back(8'($urandom_range(0, N - 1)));
        xfer_write(SADDR, -1, -1, 1'b0);
        xfer_read(nb, 1'b1);
      end
      check("rnd_reg_out", 32'(reg_out), 32'(model_pack()));
      check("rnd_busy", 32'(busy), 32'd0);
    end

    for (int k = 0; k < 2000 && (obs_bus_q.size() > 0 || exp_wr_q.size() > 0); k++)
      @(negedge clk);
    wait_clk(2);
    check("wr_q_left", 32'(exp_wr_q.size()), 32'd0);
    check("bus_q_left", 32'(exp_bus_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
